// File: rtl/iter_divider_if.sv
// Handshake and result bundle between the divider and its requester.
// The requester drives start/operands/mode; the divider drives status and results.
`timescale 1ns/1ps
interface iter_divider_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  unsigned_div;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] out_lo;
  logic [DATA_WIDTH-1:0] out_hi;
  logic                  div_by_zero;

  modport master (
    output start, operand_a, operand_b, unsigned_div,
    input  busy, done, out_lo, out_hi, div_by_zero
  );

  modport slave (
    input  start, operand_a, operand_b, unsigned_div,
    output busy, done, out_lo, out_hi, div_by_zero
  );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign fix-up in a final cycle, fixed 33-cycle latency from accept to done.
`timescale 1ns/1ps
module iter_divider #(
  parameter int DATA_WIDTH = 32  // only 32 is supported
) (
  input  logic         clk,
  input  logic         rst,
  iter_divider_if.slave bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   divisor;
  logic [W-1:0]   dividend_raw;
  logic           quo_neg;
  logic           rem_neg;
  logic [4:0]     cnt;

  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     trial_rem;
  logic [W:0]     trial_diff;
  logic [W-1:0]   quo_fixed;
  logic [W-1:0]   rem_fixed;
  logic           divisor_zero;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults first in every always_comb so no path leaves a signal
  // unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (bus.start) state_nxt = S_CALC;
      S_CALC: if (cnt == 5'd0) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      S_CALC, S_FIX: bus.busy = 1'b1;
      S_DONE:        bus.done = 1'b1;
      default: ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  // Negating 0x80000000 yields 0x80000000, which is the correct magnitude
  // when read as unsigned.
  always_comb begin
    a_mag = bus.operand_a;
    b_mag = bus.operand_b;
    if (!bus.unsigned_div) begin
      if (bus.operand_a[W-1]) a_mag = -bus.operand_a;
      if (bus.operand_b[W-1]) b_mag = -bus.operand_b;
    end
  end

  // The partial remainder is always below the divisor, so the shifted value
  // fits in W+1 bits and the borrow bit alone decides restore vs keep.
  assign trial_rem    = {rem, quo[W-1]};
  assign trial_diff   = trial_rem - {1'b0, divisor};
  assign quo_fixed    = quo_neg ? -quo : quo;
  assign rem_fixed    = rem_neg ? -rem : rem;
  assign divisor_zero = (divisor == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem             <= '0;
      quo             <= '0;
      divisor         <= '0;
      dividend_raw    <= '0;
      quo_neg         <= 1'b0;
      rem_neg         <= 1'b0;
      cnt             <= 5'd0;
      bus.out_lo      <= '0;
      bus.out_hi      <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            rem          <= '0;
            quo          <= a_mag;
            divisor      <= b_mag;
            dividend_raw <= bus.operand_a;
            quo_neg      <= !bus.unsigned_div && (bus.operand_a[W-1] ^ bus.operand_b[W-1]);
            rem_neg      <= !bus.unsigned_div && bus.operand_a[W-1];
            cnt          <= 5'd31;
          end
        end
        S_CALC: begin
          if (!trial_diff[W]) begin
            rem <= trial_diff[W-1:0];
            quo <= {quo[W-2:0], 1'b1};
          end else begin
            rem <= trial_rem[W-1:0];
            quo <= {quo[W-2:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
        end
        S_FIX: begin
          // A zero divisor overrides the iterated result in both modes.
          if (divisor_zero) begin
            bus.out_lo      <= '1;
            bus.out_hi      <= dividend_raw;
            bus.div_by_zero <= 1'b1;
          end else begin
            bus.out_lo      <= quo_fixed;
            bus.out_hi      <= rem_fixed;
            bus.div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
